// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the VGA raster generator: the mode struct,
// the standard mode sets and a width-fit helper for elaboration checks.
package vga_timing_pkg;

  // One complete raster mode: per-axis region widths plus sync polarities.
  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hs_pol;
    logic vs_pol;
  } timing_t;

  // 640x480@60, negative syncs (25.175 MHz pixel rate).
  localparam timing_t VGA_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
    hs_pol:   1'b0, vs_pol: 1'b0
  };

  // 800x600@60, positive syncs (40 MHz pixel rate).
  localparam timing_t SVGA_800X600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol:   1'b1, vs_pol: 1'b1
  };

  // True when a counter of width w can hold every count 0..total-1.
  function automatic bit fits_width(int total, int w);
    return (w >= 1) && (w <= 31) &&
           (longint'(total) <= (longint'(1) << w));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Single raster axis counter. Counts 0..TOTAL-1 on enabled clocks and
// exposes both the registered count and the count it will take on the next
// edge, so the parent can register decodes in step with the count itself.
module vga_axis_counter #(
  parameter int W     = 11,
  parameter int TOTAL = 800
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic         wrap,
  output logic [W-1:0] cnt_next,
  output logic [W-1:0] cnt
);

  // Reset parks the counter on its last value so the first enable lands on 0.
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reset wins, otherwise step or wrap on enable, else hold.
  always_comb begin
    wrap  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (reset) begin
      cnt_d = LAST;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= LAST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next = cnt_d;
  assign cnt      = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Horizontal and vertical counters
// advance on pix_en; every sync/enable/coordinate/pulse output is decoded
// from the next-state counts and registered, so all outputs line up with
// h_cnt/v_cnt on the same clock.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_640X480_60.h_active,
  parameter int   H_FP     = VGA_640X480_60.h_fp,
  parameter int   H_SYNC   = VGA_640X480_60.h_sync,
  parameter int   H_BP     = VGA_640X480_60.h_bp,
  parameter int   V_ACTIVE = VGA_640X480_60.v_active,
  parameter int   V_FP     = VGA_640X480_60.v_fp,
  parameter int   V_SYNC   = VGA_640X480_60.v_sync,
  parameter int   V_BP     = VGA_640X480_60.v_bp,
  parameter logic HS_POL   = VGA_640X480_60.hs_pol,
  parameter logic VS_POL   = VGA_640X480_60.vs_pol,
  parameter int   CW       = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Reject modes that cannot be represented rather than silently wrapping.
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_width
    $error("vga_timing_gen: every active/porch/sync width must be at least 1");
  end
  if (!fits_width(H_TOTAL, CW) || !fits_width(V_TOTAL, CW)) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL-1 or V_TOTAL-1");
  end

  // Region boundaries as CW-bit constants. The sync end is at most
  // TOTAL-1 because each back porch is at least one unit wide.
  localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_START  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic          h_wrap;
  logic          v_wrap;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;

  vga_axis_counter #(
    .W     (CW),
    .TOTAL (H_TOTAL)
  ) u_h_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (pix_en),
    .wrap     (h_wrap),
    .cnt_next (h_next),
    .cnt      (h_cnt)
  );

  // The line counter steps only on the pixel that closes a line.
  vga_axis_counter #(
    .W     (CW),
    .TOTAL (V_TOTAL)
  ) u_v_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (pix_en & h_wrap),
    .wrap     (v_wrap),
    .cnt_next (v_next),
    .cnt      (v_cnt)
  );

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          vblank_start_q, vblank_start_d;
  logic          h_active_n, v_active_n;
  logic          hs_on_n, vs_on_n;

  // Decode the counts the counters are about to take. With pix_en low the
  // next counts equal the current ones, so the levels hold, and every
  // pulse is derived from h_wrap, which already requires pix_en.
  always_comb begin
    h_active_n     = (h_next < H_ACT_END);
    v_active_n     = (v_next < V_ACT_END);
    hs_on_n        = (h_next >= HS_START) && (h_next < HS_END);
    vs_on_n        = (v_next >= VS_START) && (v_next < VS_END);
    hsync_d        = hs_on_n ? HS_POL : ~HS_POL;
    vsync_d        = vs_on_n ? VS_POL : ~VS_POL;
    de_d           = h_active_n && v_active_n;
    x_d            = h_active_n ? h_next : '0;
    y_d            = v_active_n ? v_next : '0;
    line_start_d   = h_wrap;
    frame_start_d  = h_wrap && v_wrap;
    vblank_start_d = h_wrap && (v_next == V_ACT_END);
  end

  // Output registers; reset wins over pix_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q        <= ~HS_POL;
      vsync_q        <= ~VS_POL;
      de_q           <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      de_q           <= de_d;
      x_q            <= x_d;
      y_q            <= y_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign de           = de_q;
  assign x            = x_q;
  assign y            = y_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (640x480 defaults, a tiny 8x6
// positive-polarity raster with CW=4, and the 800x600 package mode) share
// one clock, reset and pix_en. A reference raster model pushes the expected
// output set of every instance into a queue each clock; it is popped and
// compared one step after the edge. Directed checks pin down sync windows,
// frame periods and reset behaviour with literal values.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam timing_t TINY = '{
    h_active: 4, h_fp: 1, h_sync: 2, h_bp: 1,
    v_active: 3, v_fp: 1, v_sync: 1, v_bp: 1,
    hs_pol:   1'b1, vs_pol: 1'b1
  };

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic [15:0] x;
    logic [15:0] y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic        vbs;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;

  logic        hsync_a, vsync_a, de_a, ls_a, fs_a, vbs_a;
  logic [10:0] x_a, y_a, h_a, v_a;
  logic        hsync_b, vsync_b, de_b, ls_b, fs_b, vbs_b;
  logic [3:0]  x_b, y_b, h_b, v_b;
  logic        hsync_c, vsync_c, de_c, ls_c, fs_c, vbs_c;
  logic [10:0] x_c, y_c, h_c, v_c;

  always #5 clk = ~clk;

  vga_timing_gen u_dut_a (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .x(x_a), .y(y_a),
    .h_cnt(h_a), .v_cnt(v_a), .line_start(ls_a), .frame_start(fs_a),
    .vblank_start(vbs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(TINY.h_active), .H_FP(TINY.h_fp), .H_SYNC(TINY.h_sync), .H_BP(TINY.h_bp),
    .V_ACTIVE(TINY.v_active), .V_FP(TINY.v_fp), .V_SYNC(TINY.v_sync), .V_BP(TINY.v_bp),
    .HS_POL(TINY.hs_pol), .VS_POL(TINY.vs_pol), .CW(4)
  ) u_dut_b (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .x(x_b), .y(y_b),
    .h_cnt(h_b), .v_cnt(v_b), .line_start(ls_b), .frame_start(fs_b),
    .vblank_start(vbs_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(SVGA_800X600_60.h_active), .H_FP(SVGA_800X600_60.h_fp),
    .H_SYNC(SVGA_800X600_60.h_sync), .H_BP(SVGA_800X600_60.h_bp),
    .V_ACTIVE(SVGA_800X600_60.v_active), .V_FP(SVGA_800X600_60.v_fp),
    .V_SYNC(SVGA_800X600_60.v_sync), .V_BP(SVGA_800X600_60.v_bp),
    .HS_POL(SVGA_800X600_60.hs_pol), .VS_POL(SVGA_800X600_60.vs_pol), .CW(11)
  ) u_dut_c (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync(hsync_c), .vsync(vsync_c), .de(de_c), .x(x_c), .y(y_c),
    .h_cnt(h_c), .v_cnt(v_c), .line_start(ls_c), .frame_start(fs_c),
    .vblank_start(vbs_c)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   mh_a, mv_a, mh_b, mv_b, mh_c, mv_c;
  obs_t q_a[$];
  obs_t q_b[$];
  obs_t q_c[$];

  // Advance one axis pair of the reference raster by one clock.
  task automatic model_step(input timing_t m, input bit rst, input bit en,
                            inout int h, inout int v,
                            output bit ls, output bit fs, output bit vbs);
    int ht = m.h_active + m.h_fp + m.h_sync + m.h_bp;
    int vt = m.v_active + m.v_fp + m.v_sync + m.v_bp;
    ls = 1'b0; fs = 1'b0; vbs = 1'b0;
    if (rst) begin
      h = ht - 1;
      v = vt - 1;
    end else if (en) begin
      if (h == ht - 1) begin
        h  = 0;
        ls = 1'b1;
        if (v == vt - 1) begin
          v  = 0;
          fs = 1'b1;
        end else begin
          v = v + 1;
        end
        vbs = (v == m.v_active);
      end else begin
        h = h + 1;
      end
    end
  endtask

  // Expected outputs for a given raster position and pulse set.
  function automatic obs_t model_out(timing_t m, int h, int v, bit ls, bit fs, bit vbs);
    obs_t o;
    bit   hs_on = (h >= m.h_active + m.h_fp) && (h < m.h_active + m.h_fp + m.h_sync);
    bit   vs_on = (v >= m.v_active + m.v_fp) && (v < m.v_active + m.v_fp + m.v_sync);
    o.h   = 16'(h);
    o.v   = 16'(v);
    o.x   = (h < m.h_active) ? 16'(h) : 16'd0;
    o.y   = (v < m.v_active) ? 16'(v) : 16'd0;
    o.hs  = hs_on ? m.hs_pol : ~m.hs_pol;
    o.vs  = vs_on ? m.vs_pol : ~m.vs_pol;
    o.de  = (h < m.h_active) && (v < m.v_active);
    o.ls  = ls;
    o.fs  = fs;
    o.vbs = vbs;
    return o;
  endfunction

  task automatic compare(input string tag, input obs_t got, input obs_t exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // Drive one clock of stimulus, queue the model's prediction, then pop and
  // compare against the DUT once the edge has settled.
  task automatic cycle(input bit rst, input bit en);
    bit   ls, fs, vbs;
    obs_t got;
    @(negedge clk);
    reset  = rst;
    pix_en = en;
    model_step(VGA_640X480_60, rst, en, mh_a, mv_a, ls, fs, vbs);
    q_a.push_back(model_out(VGA_640X480_60, mh_a, mv_a, ls, fs, vbs));
    model_step(TINY, rst, en, mh_b, mv_b, ls, fs, vbs);
    q_b.push_back(model_out(TINY, mh_b, mv_b, ls, fs, vbs));
    model_step(SVGA_800X600_60, rst, en, mh_c, mv_c, ls, fs, vbs);
    q_c.push_back(model_out(SVGA_800X600_60, mh_c, mv_c, ls, fs, vbs));
    @(posedge clk);
    #1;
    cyc++;
    got = '{h: 16'(h_a), v: 16'(v_a), x: 16'(x_a), y: 16'(y_a), hs: hsync_a,
            vs: vsync_a, de: de_a, ls: ls_a, fs: fs_a, vbs: vbs_a};
    compare("raster_640", got, q_a.pop_front());
    got = '{h: 16'(h_b), v: 16'(v_b), x: 16'(x_b), y: 16'(y_b), hs: hsync_b,
            vs: vsync_b, de: de_b, ls: ls_b, fs: fs_b, vbs: vbs_b};
    compare("raster_tiny", got, q_b.pop_front());
    got = '{h: 16'(h_c), v: 16'(v_c), x: 16'(x_c), y: 16'(y_c), hs: hsync_c,
            vs: vsync_c, de: de_c, ls: ls_c, fs: fs_c, vbs: vbs_c};
    compare("raster_800", got, q_c.pop_front());
  endtask

  initial begin
    int hs_cnt_a  = 0;
    int hs_min_a  = 9999, hs_max_a = -1;
    int de_fall_a = -1;
    int hs_min_c  = 9999, hs_max_c = -1;
    int hs_min_b  = 99, hs_max_b = -1;
    int vs_min_b  = 99, vs_max_b = -1;
    int x_max_b   = -1;
    int last_fs   = -1;

    // Reset with pix_en low: reset values regardless of the strobe.
    repeat (3) cycle(1'b1, 1'b0);
    check("rst_h_640", int'(h_a), 799);
    check("rst_v_640", int'(v_a), 524);
    check("rst_hsync_640", int'(hsync_a), 1);
    check("rst_vsync_640", int'(vsync_a), 1);
    check("rst_de_640", int'(de_a), 0);
    check("rst_h_800", int'(h_c), 1055);
    check("rst_v_800", int'(v_c), 627);
    check("rst_hsync_800", int'(hsync_c), 0);
    check("rst_h_tiny", int'(h_b), 7);
    check("rst_v_tiny", int'(v_b), 5);

    // Free-running pixels: first clock lands on the origin, then collect
    // sync windows and tiny-raster frame periods.
    for (int i = 0; i < 1300; i++) begin
      cycle(1'b0, 1'b1);
      if (i == 0) begin
        check("first_h", int'(h_a), 0);
        check("first_v", int'(v_a), 0);
        check("first_de", int'(de_a), 1);
        check("first_frame_start", int'(fs_a), 1);
        check("first_line_start", int'(ls_a), 1);
      end
      if (v_a == 0 && !hsync_a) begin
        hs_cnt_a++;
        if (int'(h_a) < hs_min_a) hs_min_a = int'(h_a);
        if (int'(h_a) > hs_max_a) hs_max_a = int'(h_a);
      end
      if (v_a == 0 && !de_a && de_fall_a < 0) de_fall_a = int'(h_a);
      if (v_c == 0 && hsync_c) begin
        if (int'(h_c) < hs_min_c) hs_min_c = int'(h_c);
        if (int'(h_c) > hs_max_c) hs_max_c = int'(h_c);
      end
      if (hsync_b) begin
        if (int'(h_b) < hs_min_b) hs_min_b = int'(h_b);
        if (int'(h_b) > hs_max_b) hs_max_b = int'(h_b);
      end
      if (vsync_b) begin
        if (int'(v_b) < vs_min_b) vs_min_b = int'(v_b);
        if (int'(v_b) > vs_max_b) vs_max_b = int'(v_b);
      end
      if (int'(x_b) > x_max_b) x_max_b = int'(x_b);
      if (vbs_b) begin
        check("vblank_pos_tiny", int'({v_b, h_b}), int'({4'd3, 4'd0}));
        check("vblank_implies_line", int'(ls_b), 1);
      end
      if (fs_b) begin
        check("frame_implies_line", int'(ls_b), 1);
        if (last_fs >= 0) check("frame_period_tiny", cyc - last_fs, 48);
        last_fs = cyc;
      end
    end
    check("hsync_len_640", hs_cnt_a, 96);
    check("hsync_first_640", hs_min_a, 656);
    check("hsync_last_640", hs_max_a, 751);
    check("de_fall_640", de_fall_a, 640);
    check("hsync_first_800", hs_min_c, 840);
    check("hsync_last_800", hs_max_c, 967);
    check("hsync_first_tiny", hs_min_b, 5);
    check("hsync_last_tiny", hs_max_b, 6);
    check("vsync_first_tiny", vs_min_b, 4);
    check("vsync_last_tiny", vs_max_b, 4);
    check("x_max_tiny", x_max_b, 3);

    // Reset mid-line: outputs snap to reset values, then resume at origin.
    cycle(1'b1, 1'b0);
    repeat (301) cycle(1'b0, 1'b1);
    check("pre_reset_h_640", int'(h_a), 300);
    cycle(1'b1, 1'b1);
    check("midrst_h_640", int'(h_a), 799);
    check("midrst_v_640", int'(v_a), 524);
    check("midrst_de_640", int'(de_a), 0);
    check("midrst_syncs_640", int'({hsync_a, vsync_a}), 3);
    cycle(1'b0, 1'b1);
    check("resume_origin_640", int'({v_a, h_a}), 0);
    check("resume_frame_start", int'(fs_a), 1);

    // One-in-four strobe: tiny frame stretches to 4 * 48 clocks.
    last_fs = -1;
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b0, (i % 4) == 0);
      if (fs_b) begin
        if (last_fs >= 0) check("frame_period_strobe", cyc - last_fs, 192);
        last_fs = cyc;
      end
    end

    // Random strobe with occasional reset, model-checked every clock.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
